pll_phase_ctrl: RTL and testbench

//  Sequences the ECP5 EHXPLLL dynamic phase-shift port so the SDRAM clock phase is trimmed at run time.

---
 rtl/pll_phase_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the ECP5 EHXPLLL: gates system reset on stable lock,
// issues PHASESTEP/PHASELOADREG strobes and tracks the phase position of each PLL output.
module pll_phase_ctrl #(
    parameter logic [15:0] LOCK_WAIT = 16'd1024,
    parameter int          SETUP_CYC = 4,
    parameter int          PULSE_CYC = 2,
    parameter int          GAP_CYC   = 4,
    parameter int          PHASE_MOD = 48
) (
    input  logic        clkin,
    input  logic        reset_n,
    input  logic        pll_locked,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_sel,
    input  logic        req_dir,
    input  logic [5:0]  req_steps,
    output logic [1:0]  phasesel,
    output logic        phasedir,
    output logic        phasestep,
    output logic        phaseloadreg,
    output logic        done,
    output logic        lock_lost,
    output logic        sys_reset_n,
    output logic [23:0] phase_pos
);

    localparam logic [15:0] LOCK_LAST  = LOCK_WAIT - 16'd1;
    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
    localparam logic [5:0]  POS_MAX    = 6'(PHASE_MOD - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK, STABLE, IDLE, SETUP, STEP_LO, STEP_HI, LOAD, SETTLE
    } state_t;

    state_t          state;
    logic            lockMeta, lockS;
    logic [15:0]     cnt;
    logic [5:0]      remaining;
    logic [3:0][5:0] phasePos;
    logic [5:0]      curPos, stepPos;

    assign phase_pos = phasePos;

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lockMeta <= 1'b0;
            lockS    <= 1'b0;
        end else begin
            lockMeta <= pll_locked;
            lockS    <= lockMeta;
        end
    end

    always_comb begin
        curPos = phasePos[phasesel];
        if (phasedir) stepPos = (curPos == POS_MAX) ? 6'd0 : curPos + 6'd1;
        else          stepPos = (curPos == 6'd0) ? POS_MAX : curPos - 6'd1;
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            remaining    <= '0;
            phasePos     <= '0;
            phasesel     <= 2'b00;
            phasedir     <= 1'b1;
            phasestep    <= 1'b1;
            phaseloadreg <= 1'b1;
            req_ready    <= 1'b0;
            done         <= 1'b0;
            lock_lost    <= 1'b0;
            sys_reset_n  <= 1'b0;
        end else begin
            done      <= 1'b0;
            lock_lost <= 1'b0;
            // sys_reset_n doubles as the "IDLE has been reached" flag for lock-loss reporting
            if (sys_reset_n && !lockS) begin
                state        <= WAIT_LOCK;
                cnt          <= '0;
                phasestep    <= 1'b1;
                phaseloadreg <= 1'b1;
                req_ready    <= 1'b0;
                lock_lost    <= 1'b1;
                sys_reset_n  <= 1'b0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        cnt <= '0;
                        if (lockS) state <= STABLE;
                    end
                    STABLE: begin
                        if (!lockS) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == LOCK_LAST) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            sys_reset_n <= 1'b1;
                            req_ready   <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    IDLE: begin
                        if (req_valid) begin
                            phasesel  <= req_sel;
                            phasedir  <= req_dir;
                            remaining <= req_steps;
                            cnt       <= '0;
                            if (req_steps == 6'd0) begin
                                done <= 1'b1;
                            end else begin
                                state     <= SETUP;
                                req_ready <= 1'b0;
                            end
                        end
                    end
                    SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            state     <= STEP_LO;
                            cnt       <= '0;
                            phasestep <= 1'b0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    STEP_LO: begin
                        if (cnt == PULSE_LAST) begin
                            state              <= STEP_HI;
                            cnt                <= '0;
                            phasestep          <= 1'b1;
                            remaining          <= remaining - 6'd1;
                            phasePos[phasesel] <= stepPos;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    STEP_HI: begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (remaining != 6'd0) begin
                                state     <= STEP_LO;
                                phasestep <= 1'b0;
                            end else begin
                                state        <= LOAD;
                                phaseloadreg <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    LOAD: begin
                        if (cnt == PULSE_LAST) begin
                            state        <= SETTLE;
                            cnt          <= '0;
                            phaseloadreg <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    SETTLE: begin
                        if (cnt == GAP_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            done      <= 1'b1;
                            req_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= WAIT_LOCK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with LOCK_WAIT=16: lock gating, step sequencing,
// position wrap, zero-step requests, lock loss mid-step and asynchronous reset.
module tb_pll_phase_ctrl;

    logic        clkin = 1'b0;
    logic        reset_n, pll_locked, req_valid, req_dir;
    logic [1:0]  req_sel;
    logic [5:0]  req_steps;
    logic        req_ready, phasedir, phasestep, phaseloadreg, done, lock_lost, sys_reset_n;
    logic [1:0]  phasesel;
    logic [23:0] phase_pos;

    int checks = 0;
    int errors = 0;

    int obsStepLows, obsPulses, obsMinW, obsMaxW, obsLoadLows, obsLoadK;
    int obsLastStepK, obsDoneK, obsDoneCnt, obsSelBad, obsReadyBad;

    pll_phase_ctrl #(.LOCK_WAIT(16'd16)) dut (
        .clkin(clkin), .reset_n(reset_n), .pll_locked(pll_locked),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_dir(req_dir), .req_steps(req_steps), .phasesel(phasesel),
        .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
        .done(done), .lock_lost(lock_lost), .sys_reset_n(sys_reset_n),
        .phase_pos(phase_pos)
    );

    always #5 clkin = ~clkin;

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Wait for ready, present one request, accept on the next edge. Returns at k=1 of the request.
    task automatic do_req(input logic [1:0] s, input logic d, input logic [5:0] n);
        int w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait got %b want 1", req_ready);
        end
        req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Record strobe activity for n cycles starting at the current sample point.
    task automatic observe(input int n, input logic [1:0] s, input logic d);
        int w = 0;
        logic prev = 1'b1;
        obsStepLows = 0; obsPulses = 0; obsMinW = 999; obsMaxW = 0; obsLoadLows = 0;
        obsLoadK = 0; obsLastStepK = 0; obsDoneK = 0; obsDoneCnt = 0; obsSelBad = 0; obsReadyBad = 0;
        for (int k = 1; k <= n; k++) begin
            if (phasestep === 1'b0) begin
                obsStepLows++; w++; obsLastStepK = k;
            end else if (prev === 1'b0) begin
                obsPulses++;
                if (w < obsMinW) obsMinW = w;
                if (w > obsMaxW) obsMaxW = w;
                w = 0;
            end
            prev = phasestep;
            if (phaseloadreg === 1'b0) begin
                obsLoadLows++;
                if (obsLoadK == 0) obsLoadK = k;
            end
            if (done === 1'b1) begin
                obsDoneCnt++;
                if (obsDoneK == 0) obsDoneK = k;
            end
            if (obsDoneK == 0 && (phasesel !== s || phasedir !== d)) obsSelBad++;
            if (obsDoneK == 0 && req_ready === 1'b1) obsReadyBad++;
            tick();
        end
    endtask

    task automatic check_release(input string tag);
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e == 18) begin
                checks++;
                if (sys_reset_n !== 1'b0 || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_early rst=%b rdy=%b want 0 0", tag, sys_reset_n, req_ready);
                end
            end
        end
        checks++;
        if (sys_reset_n !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release rst=%b rdy=%b want 1 1", tag, sys_reset_n, req_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1; pll_locked = 1'b1; req_valid = 1'b0;
        req_sel = 2'b00; req_dir = 1'b0; req_steps = 6'd0;
        #3 reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({phasesel, phasedir, phasestep, phaseloadreg} !== 5'b00111 ||
            {req_ready, done, lock_lost, sys_reset_n} !== 4'b0000 || phase_pos !== 24'h0) begin
            errors++;
            $display("FAIL reset_values sel=%b dir=%b ps=%b pl=%b rdy=%b dn=%b ll=%b sr=%b pos=%h",
                     phasesel, phasedir, phasestep, phaseloadreg, req_ready, done, lock_lost,
                     sys_reset_n, phase_pos);
        end
        reset_n = 1'b1;
        check_release("lock_wait");
    endtask

    task automatic test_steps();
        do_req(2'b01, 1'b1, 6'd3);
        observe(32, 2'b01, 1'b1);
        checks++;
        if (obsStepLows != 6 || obsPulses != 3 || obsMinW != 2 || obsMaxW != 2) begin
            errors++;
            $display("FAIL step_pulses lows=%0d pulses=%0d minw=%0d maxw=%0d want 6 3 2 2",
                     obsStepLows, obsPulses, obsMinW, obsMaxW);
        end
        checks++;
        if (obsLoadLows != 2 || obsLoadK != 23 || obsLastStepK != 18) begin
            errors++;
            $display("FAIL load_pulse lows=%0d at=%0d laststep=%0d want 2 23 18",
                     obsLoadLows, obsLoadK, obsLastStepK);
        end
        checks++;
        if (obsDoneK != 29 || obsDoneCnt != 1) begin
            errors++;
            $display("FAIL step3_done at=%0d cnt=%0d want 29 1", obsDoneK, obsDoneCnt);
        end
        checks++;
        if (obsSelBad != 0 || obsReadyBad != 0) begin
            errors++;
            $display("FAIL sel_stable selbad=%0d readybad=%0d want 0 0", obsSelBad, obsReadyBad);
        end
        checks++;
        if (phase_pos !== 24'h0000C0) begin
            errors++;
            $display("FAIL step3_pos got %h want 0000c0", phase_pos);
        end
    endtask

    task automatic test_wrap();
        do_req(2'b00, 1'b0, 6'd1);
        observe(20, 2'b00, 1'b0);
        checks++;
        if (obsDoneK != 17 || obsStepLows != 2 || obsSelBad != 0) begin
            errors++;
            $display("FAIL adv1_seq done=%0d lows=%0d selbad=%0d want 17 2 0",
                     obsDoneK, obsStepLows, obsSelBad);
        end
        checks++;
        if (phase_pos !== 24'h0000EF) begin
            errors++;
            $display("FAIL wrap_down got %h want 0000ef", phase_pos);
        end
        do_req(2'b00, 1'b1, 6'd1);
        observe(20, 2'b00, 1'b1);
        checks++;
        if (phase_pos !== 24'h0000C0) begin
            errors++;
            $display("FAIL wrap_up got %h want 0000c0", phase_pos);
        end
    endtask

    task automatic test_zero_steps();
        do_req(2'b10, 1'b1, 6'd0);
        observe(6, 2'b10, 1'b1);
        checks++;
        if (obsDoneK != 1 || obsDoneCnt != 1 || obsStepLows != 0 || obsLoadLows != 0) begin
            errors++;
            $display("FAIL zero_steps done=%0d cnt=%0d steps=%0d loads=%0d want 1 1 0 0",
                     obsDoneK, obsDoneCnt, obsStepLows, obsLoadLows);
        end
        checks++;
        if (phase_pos !== 24'h0000C0) begin
            errors++;
            $display("FAIL zero_pos got %h want 0000c0", phase_pos);
        end
    endtask

    task automatic test_lock_loss();
        logic ps11, ll12, sr12, ps12, pl12, ll13;
        int doneCnt = 0;
        int llCnt = 0;
        ps11 = 1'bx; ll12 = 1'bx; sr12 = 1'bx; ps12 = 1'bx; pl12 = 1'bx; ll13 = 1'bx;
        do_req(2'b11, 1'b1, 6'd5);
        for (int k = 1; k <= 20; k++) begin
            if (k == 11) ps11 = phasestep;
            if (k == 12) begin
                ll12 = lock_lost; sr12 = sys_reset_n; ps12 = phasestep; pl12 = phaseloadreg;
            end
            if (k == 13) ll13 = lock_lost;
            if (done === 1'b1) doneCnt++;
            if (lock_lost === 1'b1) llCnt++;
            if (k == 9) pll_locked = 1'b0;
            tick();
        end
        checks++;
        if (ps11 !== 1'b0) begin
            errors++;
            $display("FAIL second_step_low got %b want 0", ps11);
        end
        checks++;
        if (ll12 !== 1'b1 || sr12 !== 1'b0 || ps12 !== 1'b1 || pl12 !== 1'b1 || ll13 !== 1'b0) begin
            errors++;
            $display("FAIL lock_lost_resp ll=%b sr=%b ps=%b pl=%b ll_next=%b want 1 0 1 1 0",
                     ll12, sr12, ps12, pl12, ll13);
        end
        checks++;
        if (doneCnt != 0 || llCnt != 1) begin
            errors++;
            $display("FAIL abort_pulses done=%0d lost=%0d want 0 1", doneCnt, llCnt);
        end
        checks++;
        if (phase_pos !== 24'h0400C0) begin
            errors++;
            $display("FAIL abort_pos got %h want 0400c0", phase_pos);
        end
        pll_locked = 1'b1;
        check_release("relock");
    endtask

    task automatic test_async_reset();
        req_sel = 2'b01; req_dir = 1'b1; req_steps = 6'd2; req_valid = 1'b1;
        tick();
        for (int k = 1; k < 5; k++) tick();
        checks++;
        if (phasestep !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_step got %b want 0", phasestep);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({phasesel, phasedir, phasestep, phaseloadreg} !== 5'b00111 ||
            {req_ready, done, lock_lost, sys_reset_n} !== 4'b0000 || phase_pos !== 24'h0) begin
            errors++;
            $display("FAIL async_reset sel=%b dir=%b ps=%b pl=%b rdy=%b dn=%b ll=%b sr=%b pos=%h",
                     phasesel, phasedir, phasestep, phaseloadreg, req_ready, done, lock_lost,
                     sys_reset_n, phase_pos);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        check_release("post_reset");
        checks++;
        if (phasesel !== 2'b00) begin
            errors++;
            $display("FAIL held_req_early sel=%b want 00", phasesel);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (phasesel !== 2'b01 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_req_accept sel=%b rdy=%b want 01 0", phasesel, req_ready);
        end
        observe(26, 2'b01, 1'b1);
        checks++;
        if (obsDoneK != 23 || obsPulses != 2 || phase_pos !== 24'h000080) begin
            errors++;
            $display("FAIL post_reset_req done=%0d pulses=%0d pos=%h want 23 2 000080",
                     obsDoneK, obsPulses, phase_pos);
        end
    endtask

    initial begin
        test_reset();
        test_steps();
        test_wrap();
        test_zero_steps();
        test_lock_loss();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
